instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//   Parametrised MIPS fetch stage: PC register, on-chip instruction memory and IF/ID register.
//   Adds features the basic fetch block lacks:
//   - stall
//   - branch/jump redirect with flush
//   - fault detection with a halt state
//   - a runtime memory write (load) port
//   - a fetch counter
//   Sits between the PC-select logic and the decode stage; all state updates on posedge CLK.
// PARAMETERS
//   ADDR_WIDTH  32      width of PC and all byte addresses
//   IMEM_DEPTH  4096    instruction memory size, 32-bit words (index width = clog2(IMEM_DEPTH))
//   RESET_PC    0       PC value loaded on reset
//   CNT_WIDTH   32      width of FETCH_COUNT
// PORTS
//   CLK          in   1           clock, all state on rising edge
//   RESET_N      in   1           asynchronous, active-low reset
//   STALL        in   1           hold PC and IF/ID register (decode hazard)
//   REDIRECT     in   1           taken branch/jump: load REDIRECT_PC, flush IF/ID
//   REDIRECT_PC  in   ADDR_WIDTH  redirect target (byte address)
//   IMEM_WE      in   1           instruction memory write enable
//   IMEM_WADDR   in   ADDR_WIDTH  write byte address; bits [1:0] ignored
//   IMEM_WDATA   in   32          write data
//   PC           out  ADDR_WIDTH  address of the word being fetched this cycle
//   IR           out  32          IF/ID instruction
//   IR_PC        out  ADDR_WIDTH  address IR was fetched from
//   IR_PC4       out  ADDR_WIDTH  IR_PC + 4 (for branch/link)
//   IR_VALID     out  1           IR holds a real instruction (0 = bubble)
//   FAULT        out  1           sticky fetch fault (misaligned or out-of-range PC)
//   FETCH_COUNT  out  CNT_WIDTH   number of valid instructions delivered
// BEHAVIOUR
//   Reset (RESET_N=0, async):
//   - PC=RESET_PC; IR=0 (NOP); IR_PC=0; IR_PC4=0; IR_VALID=0; FAULT=0; FETCH_COUNT=0; state=RUN.
//   Memory:
//   - Combinational read: imem[PC[idx+1:2]].
//   - Write is synchronous on posedge when IMEM_WE=1.
//   - Same-word read/write in one cycle: the fetch gets the old data.
//   Fault condition:
//   - PC[1:0]!=0, or (PC>>2) >= IMEM_DEPTH.
//   FSM RUN / HALTED. Per posedge, priority REDIRECT > STALL > fault > normal.
//   - REDIRECT (any state):
//     - PC<=REDIRECT_PC; IR_VALID<=0; IR unchanged; FAULT<=0; state<=RUN.
//     - REDIRECT_PC is not checked here; a bad target faults on the next cycle.
//   - STALL (RUN):
//     - PC, IR, IR_PC, IR_PC4, IR_VALID, FETCH_COUNT all hold.
//     - No fault check (no fetch performed).
//   - Fault (RUN, no STALL):
//     - IR_VALID<=0; FAULT<=1; state<=HALTED; PC holds.
//   - Normal (RUN):
//     - IR<=imem[PC]; IR_PC<=PC; IR_PC4<=PC+4; IR_VALID<=1.
//     - PC<=PC+4; FETCH_COUNT<=FETCH_COUNT+1.
//   - HALTED, no REDIRECT:
//     - Everything holds, IR_VALID=0, STALL ignored.
//     - Only REDIRECT or reset leaves HALTED.
//   Latency and widths:
//   - Latency 1: the word at PC appears on IR at the next posedge.
//   - One bubble follows every REDIRECT.
//   - PC+4 wraps modulo 2^ADDR_WIDTH.
//   - FETCH_COUNT wraps modulo 2^CNT_WIDTH.
//   Reset asserted mid-operation: immediate return to reset values; memory contents kept.
// TESTING
//   - Reset release, imem[0..3]=A,B,C,D, RESET_PC=0 -> posedges 1..4 give IR=A,B,C,D.
//     IR_PC=0,4,8,C; IR_VALID=1; FETCH_COUNT=4; PC=0x10.
//   - STALL=1 for 2 cycles after IR=B -> IR=B, PC=8, FETCH_COUNT=2 held.
//     Release gives IR=C next edge.
//   - REDIRECT=1, REDIRECT_PC=0x40 with STALL=1 the same edge -> IR_VALID=0, PC=0x40.
//     Next edge IR=imem[16], IR_PC=0x40.
//   - REDIRECT_PC=0x42 -> next edge FAULT=1, IR_VALID=0, HALTED.
//     PC holds 0x42 for 3 cycles. REDIRECT to 0x0 -> FAULT=0, resumes.
//   - IMEM_DEPTH=16, PC reaches 0x40 -> FAULT=1 (out of range).
//     FETCH_COUNT stops at 16 with RESET_PC=0.
//   - IMEM_WE writes 0x2001_0005 to word 2 while PC=8 -> IR gets old word.
//     Re-fetch of word 2 after REDIRECT to 8 returns 0x2001_0005.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: MIPS fetch stage with PC register, instruction memory and IF/ID register
//   CLK, RESET_N                     clock, asynchronous active-low reset
//   STALL                            hold PC and IF/ID register
//   REDIRECT, REDIRECT_PC            load new PC, bubble IF/ID, clear fault, leave HALTED
//   IMEM_WE, IMEM_WADDR, IMEM_WDATA  synchronous instruction memory write (byte address)
//   PC                               address being fetched this cycle
//   IR, IR_PC, IR_PC4, IR_VALID      IF/ID register
//   FAULT                            sticky misaligned/out-of-range fetch, halts until REDIRECT
//   FETCH_COUNT                      number of valid instructions delivered
module instruction_fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int IMEM_DEPTH = 4096,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  STALL,
  input  logic                  REDIRECT,
  input  logic [ADDR_WIDTH-1:0] REDIRECT_PC,
  input  logic                  IMEM_WE,
  input  logic [ADDR_WIDTH-1:0] IMEM_WADDR,
  input  logic [31:0]           IMEM_WDATA,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic [31:0]           IR,
  output logic [ADDR_WIDTH-1:0] IR_PC,
  output logic [ADDR_WIDTH-1:0] IR_PC4,
  output logic                  IR_VALID,
  output logic                  FAULT,
  output logic [CNT_WIDTH-1:0]  FETCH_COUNT
);
  localparam int IW = $clog2(IMEM_DEPTH);
  typedef enum logic {RUN, HALTED} state_e;
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, ir_pc_q, ir_pc_d, ir_pc4_q, ir_pc4_d;
  logic [31:0] ir_q, ir_d;
  logic ir_valid_q, ir_valid_d, fault_q, fault_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0] imem [IMEM_DEPTH];
  logic [ADDR_WIDTH-1:0] rword, wword, pc4;
  logic bad;
  assign rword = pc_q >> 2;
  assign wword = IMEM_WADDR >> 2;
  assign pc4 = pc_q + ADDR_WIDTH'(4);
  assign bad = (pc_q[1:0] != 2'b00) || (rword >= ADDR_WIDTH'(IMEM_DEPTH));
  // Write lands at the edge, so a same-cycle fetch of that word still sees the old data.
  always_ff @(posedge CLK)
    if (IMEM_WE && wword < ADDR_WIDTH'(IMEM_DEPTH)) imem[wword[IW-1:0]] <= IMEM_WDATA;
  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    ir_pc_d = ir_pc_q;
    ir_pc4_d = ir_pc4_q;
    ir_valid_d = ir_valid_q;
    fault_d = fault_q;
    cnt_d = cnt_q;
    state_d = state_q;
    if (REDIRECT) begin
      pc_d = REDIRECT_PC;
      ir_valid_d = 1'b0;
      fault_d = 1'b0;
      state_d = RUN;
    end else if (state_q == RUN && !STALL) begin
      if (bad) begin
        ir_valid_d = 1'b0;
        fault_d = 1'b1;
        state_d = HALTED;
      end else begin
        ir_d = imem[rword[IW-1:0]];
        ir_pc_d = pc_q;
        ir_pc4_d = pc4;
        ir_valid_d = 1'b1;
        pc_d = pc4;
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state_q <= RUN;
      pc_q <= RESET_PC;
      ir_q <= '0;
      ir_pc_q <= '0;
      ir_pc4_q <= '0;
      ir_valid_q <= 1'b0;
      fault_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      ir_pc_q <= ir_pc_d;
      ir_pc4_q <= ir_pc4_d;
      ir_valid_q <= ir_valid_d;
      fault_q <= fault_d;
      cnt_q <= cnt_d;
    end
  assign PC = pc_q;
  assign IR = ir_q;
  assign IR_PC = ir_pc_q;
  assign IR_PC4 = ir_pc4_q;
  assign IR_VALID = ir_valid_q;
  assign FAULT = fault_q;
  assign FETCH_COUNT = cnt_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed and random checks of the fetch stage against a behavioural model
module tb_instruction_fetch_unit;
  localparam int AW = 32, DEPTH = 16, CW = 8;
  logic clk = 1'b0, rst_n = 1'b1, stall = 1'b0, redirect = 1'b0, imem_we = 1'b0;
  logic [AW-1:0] redirect_pc = '0, imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic [AW-1:0] pc, ir_pc, ir_pc4;
  logic [31:0] ir;
  logic ir_valid, fault;
  logic [CW-1:0] fetch_count;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;
  logic [31:0] m_mem [DEPTH];
  logic [AW-1:0] m_pc, m_irpc, m_irpc4;
  logic [31:0] m_ir;
  bit m_valid, m_fault, m_halt;
  logic [CW-1:0] m_cnt;
  always #5 clk = ~clk;
  instruction_fetch_unit #(.ADDR_WIDTH(AW), .IMEM_DEPTH(DEPTH), .RESET_PC('0), .CNT_WIDTH(CW)) dut (
    .CLK(clk), .RESET_N(rst_n), .STALL(stall), .REDIRECT(redirect), .REDIRECT_PC(redirect_pc),
    .IMEM_WE(imem_we), .IMEM_WADDR(imem_waddr), .IMEM_WDATA(imem_wdata),
    .PC(pc), .IR(ir), .IR_PC(ir_pc), .IR_PC4(ir_pc4), .IR_VALID(ir_valid), .FAULT(fault),
    .FETCH_COUNT(fetch_count)
  );
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  function automatic void model_reset();
    m_pc = '0;
    m_ir = '0;
    m_irpc = '0;
    m_irpc4 = '0;
    m_valid = 1'b0;
    m_fault = 1'b0;
    m_halt = 1'b0;
    m_cnt = '0;
  endfunction
  function automatic void model_step();
    logic [AW-1:0] w;
    w = imem_waddr >> 2;
    if (!rst_n) model_reset();
    else if (redirect) begin
      m_pc = redirect_pc;
      m_valid = 1'b0;
      m_fault = 1'b0;
      m_halt = 1'b0;
    end else if (!m_halt && !stall) begin
      if (m_pc % 4 != 0 || m_pc / 4 >= DEPTH) begin
        m_valid = 1'b0;
        m_fault = 1'b1;
        m_halt = 1'b1;
      end else begin
        m_ir = m_mem[m_pc / 4];
        m_irpc = m_pc;
        m_irpc4 = m_pc + 4;
        m_valid = 1'b1;
        m_pc = m_pc + 4;
        m_cnt = m_cnt + 1'b1;
      end
    end
    if (imem_we && w < DEPTH) m_mem[w] = imem_wdata;
  endfunction
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask
  always @(negedge clk)
    if (chk_en) begin
      chk("PC", pc, m_pc);
      chk("IR", ir, m_ir);
      chk("IR_PC", ir_pc, m_irpc);
      chk("IR_PC4", ir_pc4, m_irpc4);
      chk("IR_VALID", ir_valid, m_valid);
      chk("FAULT", fault, m_fault);
      chk("FETCH_COUNT", fetch_count, m_cnt);
    end
  initial begin
    #1 rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      imem_we = 1'b1;
      imem_waddr = 32'(i * 4);
      imem_wdata = 32'hA500_0000 | 32'(i);
      cyc();
    end
    imem_we = 1'b0;
    chk_en = 1'b1;
    cyc();
    chk("lit_rst_pc", pc, 0);
    chk("lit_rst_ir", ir, 0);
    chk("lit_rst_valid", ir_valid, 0);
    chk("lit_rst_cnt", fetch_count, 0);
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("lit_ir_b", ir, 32'hA500_0001);
    chk("lit_pc_8", pc, 32'h8);
    stall = 1'b1;
    cyc();
    cyc();
    chk("lit_stall_ir", ir, 32'hA500_0001);
    chk("lit_stall_pc", pc, 32'h8);
    chk("lit_stall_cnt", fetch_count, 2);
    stall = 1'b0;
    cyc();
    chk("lit_ir_c", ir, 32'hA500_0002);
    cyc();
    chk("lit_ir_d", ir, 32'hA500_0003);
    chk("lit_irpc_c", ir_pc, 32'hC);
    chk("lit_irpc4_10", ir_pc4, 32'h10);
    chk("lit_pc_10", pc, 32'h10);
    chk("lit_cnt_4", fetch_count, 4);
    redirect = 1'b1;
    redirect_pc = 32'h20;
    stall = 1'b1;
    cyc();
    chk("lit_redir_valid", ir_valid, 0);
    chk("lit_redir_pc", pc, 32'h20);
    chk("lit_redir_ir_kept", ir, 32'hA500_0003);
    redirect = 1'b0;
    stall = 1'b0;
    cyc();
    chk("lit_ir_w8", ir, 32'hA500_0008);
    chk("lit_irpc_20", ir_pc, 32'h20);
    redirect = 1'b1;
    redirect_pc = 32'h42;
    cyc();
    redirect = 1'b0;
    cyc();
    chk("lit_mis_fault", fault, 1);
    chk("lit_mis_valid", ir_valid, 0);
    stall = 1'b1;
    cyc();
    stall = 1'b0;
    cyc();
    cyc();
    chk("lit_halt_pc", pc, 32'h42);
    chk("lit_halt_cnt", fetch_count, 5);
    redirect = 1'b1;
    redirect_pc = 32'h0;
    cyc();
    redirect = 1'b0;
    chk("lit_unhalt_fault", fault, 0);
    cyc();
    chk("lit_resume_ir", ir, 32'hA500_0000);
    chk("lit_resume_valid", ir_valid, 1);
    rst_n = 1'b0;
    model_reset();
    cyc();
    rst_n = 1'b1;
    repeat (20) cyc();
    chk("lit_range_fault", fault, 1);
    chk("lit_range_cnt", fetch_count, 16);
    chk("lit_range_pc", pc, 32'h40);
    chk("lit_range_ir", ir, 32'hA500_000F);
    rst_n = 1'b0;
    model_reset();
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    imem_we = 1'b1;
    imem_waddr = 32'h8;
    imem_wdata = 32'h2001_0005;
    cyc();
    imem_we = 1'b0;
    chk("lit_wr_old", ir, 32'hA500_0002);
    redirect = 1'b1;
    redirect_pc = 32'h8;
    cyc();
    redirect = 1'b0;
    cyc();
    chk("lit_wr_new", ir, 32'h2001_0005);
    chk("lit_wr_irpc", ir_pc, 32'h8);
    for (int k = 0; k < 3000; k++) begin
      stall = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 9) == 0);
      redirect_pc = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 'h4F)) : 32'($urandom_range(0, 15)) << 2;
      imem_we = ($urandom_range(0, 4) == 0);
      imem_waddr = 32'($urandom_range(0, 'h4F));
      imem_wdata = $urandom;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end
      cyc();
    end
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
